sorted_stream_tx: RTL and testbench

SORTED_STREAM_TX -- requirements
Module: sorted_stream_tx

---
 rtl/sort_pkg.sv | 15 +
 rtl/st_skid_buffer.sv | 45 ++++
 rtl/sorted_stream_tx.sv | 113 +++++++++++
 tb/tb_sorted_stream_tx.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sort_pkg.sv
// Shared types and constants for the sort/stream datapath.
// Holds the stream-transmitter state encoding used across the block.
package sort_pkg;

  localparam int SORT_DWIDTH = 32;
  localparam int SORT_AWIDTH = 4;
  localparam int SKID_DEPTH  = 2;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DONE
  } tx_state_e;

endpackage

// File: rtl/st_skid_buffer.sv
// Two-entry output buffer with a registered head entry.
// The head is zeroed whenever it holds nothing, so tag bits idle low.
module st_skid_buffer #(
  parameter int W = 34
) (
  input  logic         clk,
  input  logic         srst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         ready,
  output logic [W-1:0] data,
  output logic         valid,
  output logic [1:0]   count
);

  logic [W-1:0] skid;
  logic         skid_v;
  logic         pop;

  assign pop   = valid & ready;
  assign count = {1'b0, valid} + {1'b0, skid_v};

  always_ff @(posedge clk) begin
    if (srst) begin
      data   <= '0;
      valid  <= 1'b0;
      skid   <= '0;
      skid_v <= 1'b0;
    end else if (!valid || pop) begin
      if (skid_v) begin
        data   <= skid;
        valid  <= 1'b1;
        skid_v <= push;
        skid   <= push ? push_data : '0;
      end else begin
        valid <= push;
        data  <= push ? push_data : '0;
      end
    end else if (push) begin
      skid   <= push_data;
      skid_v <= 1'b1;
    end
  end

endmodule

// File: rtl/sorted_stream_tx.sv
// Streams a packet of len words from a synchronous RAM
// onto an Avalon-ST source with back-pressure.
module sorted_stream_tx #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 4
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic              start_i,
  input  logic [AWIDTH:0]   len_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [AWIDTH-1:0] ram_addr_o,
  output logic              ram_rden_o,
  input  logic [DWIDTH-1:0] ram_q_i,
  output logic [DWIDTH-1:0] data_o,
  output logic              valid_o,
  output logic              startofpacket_o,
  output logic              endofpacket_o,
  input  logic              ready_i
);

  import sort_pkg::*;

  localparam logic [AWIDTH:0] MAX_LEN = {1'b1, {AWIDTH{1'b0}}};
  localparam logic [AWIDTH:0] ONE     = (AWIDTH+1)'(1);

  tx_state_e         state;
  logic [AWIDTH:0]   len_q;
  logic [AWIDTH:0]   rd_cnt;
  logic [AWIDTH:0]   push_cnt;
  logic [AWIDTH-1:0] addr;
  logic              qv;
  logic              pop;
  logic              rden;
  logic [1:0]        occ;
  logic [2:0]        fill;
  logic [DWIDTH+1:0] push_data;
  logic [DWIDTH+1:0] buf_data;
  logic              buf_valid;

  assign pop = buf_valid & ready_i;

  // Entries held after this edge; a read issued now lands one cycle later.
  assign fill = {1'b0, occ} + {2'b0, qv} - {2'b0, pop};

  assign rden = (state == STREAM) & ~srst_i &
                (rd_cnt < len_q) & (fill < 3'd2);

  assign push_data = {push_cnt == '0,
                      push_cnt == len_q - ONE,
                      ram_q_i};

  assign ram_rden_o      = rden;
  assign ram_addr_o      = addr;
  assign busy_o          = state != IDLE;
  assign done_o          = state == DONE;
  assign valid_o         = buf_valid;
  assign data_o          = buf_data[DWIDTH-1:0];
  assign endofpacket_o   = buf_data[DWIDTH];
  assign startofpacket_o = buf_data[DWIDTH+1];

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state    <= IDLE;
      len_q    <= '0;
      rd_cnt   <= '0;
      push_cnt <= '0;
      addr     <= '0;
      qv       <= 1'b0;
    end else begin
      qv <= rden;
      if (qv)
        push_cnt <= push_cnt + ONE;
      if (rden) begin
        rd_cnt <= rd_cnt + ONE;
        if (rd_cnt + ONE < len_q)
          addr <= addr + AWIDTH'(1);
      end
      unique case (state)
        IDLE: begin
          if (start_i && len_i != '0) begin
            state    <= STREAM;
            len_q    <= (len_i > MAX_LEN) ? MAX_LEN : len_i;
            rd_cnt   <= '0;
            push_cnt <= '0;
            addr     <= '0;
          end
        end
        STREAM: begin
          if (pop && endofpacket_o)
            state <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  st_skid_buffer #(
    .W(DWIDTH + 2)
  ) u_skid (
    .clk       (clk_i),
    .srst      (srst_i),
    .push      (qv),
    .push_data (push_data),
    .ready     (ready_i),
    .data      (buf_data),
    .valid     (buf_valid),
    .count     (occ)
  );

endmodule

// File: tb/tb_sorted_stream_tx.sv
// Randomized bench for sorted_stream_tx against a packet-level
// model: expected beats are mem[0..min(len,16)-1] in order.
module tb_sorted_stream_tx;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          srst_i;
  logic          start_i;
  logic [AW:0]   len_i;
  logic          busy_o;
  logic          done_o;
  logic [AW-1:0] ram_addr_o;
  logic          ram_rden_o;
  logic [DW-1:0] ram_q_i;
  logic [DW-1:0] data_o;
  logic          valid_o;
  logic          sop;
  logic          eop;
  logic          ready_i;

  typedef struct {
    int            at;
    logic [DW-1:0] d;
    logic          s;
    logic          e;
  } beat_t;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int c0     = 0;
  int b0     = 0;
  int r0     = 0;
  int d0     = 0;
  int done_cnt = 0;
  int done_at  = 0;
  bit rnd_ready = 1'b0;

  logic [DW-1:0] mem [DEPTH];
  beat_t         beats[$];
  int            reads[$];
  logic          stall_q = 1'b0;
  logic [DW+1:0] hold_q  = '0;

  sorted_stream_tx #(
    .DWIDTH(DW),
    .AWIDTH(AW)
  ) dut (
    .clk_i           (clk),
    .srst_i          (srst_i),
    .start_i         (start_i),
    .len_i           (len_i),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .ram_addr_o      (ram_addr_o),
    .ram_rden_o      (ram_rden_o),
    .ram_q_i         (ram_q_i),
    .data_o          (data_o),
    .valid_o         (valid_o),
    .startofpacket_o (sop),
    .endofpacket_o   (eop),
    .ready_i         (ready_i)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk)
    if (ram_rden_o) ram_q_i <= mem[ram_addr_o];

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (stall_q) begin
      check("stall_valid", 64'(valid_o), 64'd1);
      check("stall_hold", 64'({sop, eop, data_o}), 64'(hold_q));
    end
    stall_q <= valid_o && !ready_i && !srst_i;
    hold_q  <= {sop, eop, data_o};
    if (ram_rden_o) reads.push_back(int'(ram_addr_o));
    if (valid_o && ready_i) beats.push_back('{cyc, data_o, sop, eop});
    if (done_o) begin
      done_cnt++;
      done_at = cyc;
      check("busy_at_done", 64'(busy_o), 64'd1);
    end
  end

  initial begin
    ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      ready_i = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_mem();
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
  endtask

  task automatic do_start(input int l);
    srst_i  = 1'b0;
    start_i = 1'b1;
    len_i   = (AW+1)'(l);
    c0 = cyc;
    b0 = beats.size();
    r0 = reads.size();
    d0 = done_cnt;
    tick();
    start_i = 1'b0;
  endtask

  task automatic run_pkt(input string nm, input int l,
                         input bit rnd, input bit poke);
    int n;
    bit got;
    n = (l > DEPTH) ? DEPTH : l;
    got = 1'b0;
    rnd_ready = rnd;
    do_start(l);
    for (int i = 0; i < 500 && !got; i++) begin
      if (poke && i == 1) begin
        start_i = 1'b1;
        len_i   = 5'd5;
      end else begin
        start_i = 1'b0;
      end
      tick();
      got = (done_cnt != d0);
    end
    start_i = 1'b0;
    check({nm, "_done_seen"}, 64'(got), 64'd1);
    repeat (3) tick();
    rnd_ready = 1'b0;
    check({nm, "_done_cnt"}, 64'(done_cnt - d0), 64'd1);
    check({nm, "_busy_end"}, 64'(busy_o), 64'd0);
    check({nm, "_beats"}, 64'(beats.size() - b0), 64'(n));
    check({nm, "_reads"}, 64'(reads.size() - r0), 64'(n));
    for (int i = 0; i < n; i++) begin
      if (b0 + i < beats.size()) begin
        check({nm, "_data"}, 64'(beats[b0+i].d), 64'(mem[i]));
        check({nm, "_sop"}, 64'(beats[b0+i].s), 64'(i == 0));
        check({nm, "_eop"}, 64'(beats[b0+i].e), 64'(i == n - 1));
        if (!rnd)
          check({nm, "_beat_cyc"}, 64'(beats[b0+i].at - c0), 64'(3 + i));
      end
      if (r0 + i < reads.size())
        check({nm, "_addr"}, 64'(reads[r0+i]), 64'(i));
    end
    if (!rnd && got)
      check({nm, "_done_cyc"}, 64'(done_at - c0), 64'(3 + n));
  endtask

  initial begin
    int da;
    int ra;
    bit ok;
    srst_i  = 1'b1;
    start_i = 1'b0;
    len_i   = '0;
    repeat (3) tick();
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_valid", 64'(valid_o), 64'd0);
    check("rst_rden", 64'(ram_rden_o), 64'd0);
    check("rst_addr", 64'(ram_addr_o), 64'd0);
    check("rst_data", 64'(data_o), 64'd0);
    check("rst_sopeop", 64'({sop, eop}), 64'd0);
    srst_i = 1'b0;
    tick();

    fill_mem();
    mem[0] = 32'd10;
    mem[1] = 32'd20;
    mem[2] = 32'd30;
    mem[3] = 32'd40;
    run_pkt("basic", 4, 1'b0, 1'b0);

    fill_mem();
    run_pkt("single", 1, 1'b0, 1'b0);

    fill_mem();
    run_pkt("full_bp", 16, 1'b1, 1'b0);

    d0 = done_cnt;
    r0 = reads.size();
    start_i = 1'b1;
    len_i   = '0;
    tick();
    start_i = 1'b0;
    check("len0_busy", 64'(busy_o), 64'd0);
    repeat (10) tick();
    check("len0_reads", 64'(reads.size() - r0), 64'd0);
    check("len0_done", 64'(done_cnt - d0), 64'd0);

    fill_mem();
    run_pkt("busy_poke", 4, 1'b1, 1'b1);

    fill_mem();
    rnd_ready = 1'b0;
    do_start(8);
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      ok = (beats.size() - b0 >= 2);
      if (!ok) tick();
    end
    check("abort_two_beats", 64'(ok), 64'd1);
    da = done_cnt;
    ra = reads.size();
    srst_i = 1'b1;
    tick();
    check("abort_valid", 64'(valid_o), 64'd0);
    check("abort_busy", 64'(busy_o), 64'd0);
    check("abort_rden", 64'(ram_rden_o), 64'd0);
    check("abort_addr", 64'(ram_addr_o), 64'd0);
    check("abort_data", 64'(data_o), 64'd0);
    check("abort_sopeop", 64'({sop, eop}), 64'd0);
    check("abort_no_read", 64'(reads.size() - ra), 64'd0);
    check("abort_no_done", 64'(done_cnt - da), 64'd0);
    fill_mem();
    run_pkt("after_rst", 3, 1'b0, 1'b0);

    fill_mem();
    run_pkt("saturate", 20, 1'b1, 1'b0);

    for (int k = 0; k < 6; k++) begin
      fill_mem();
      run_pkt("rand", int'($urandom_range(1, 31)),
              1'($urandom_range(0, 1)), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
